exe_muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for RV64M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms).

---
 rtl/exe_md_pkg.sv | 25 ++
 rtl/md_step.sv | 36 +++
 rtl/exe_muldiv_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_exe_muldiv_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/exe_md_pkg.sv
// Shared constants and types for the RV64M multiply/divide sequencer.
// Holds funct3 encodings, major opcodes and the sequencer state enum.
// Optional feature macro used by the sequencer: MULDIV_FAST_MUL_EN.
package exe_md_pkg;

  localparam int MD_XLEN  = 64;
  localparam int MD_CNT_W = 7;
  localparam int MD_WLEN  = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP32     = 7'b0111011;
  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_e;

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on {acc, q}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module md_step
  import exe_md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            i_div,
  input  logic [XLEN:0]   i_acc,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_op,
  output logic [XLEN:0]   o_acc,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_sh;
  logic          w_ge;

  // Multiply: add multiplicand on q[0], then shift {acc,q} right.
  // Divide: shift {acc,q} left, subtract divisor if it fits, set quotient bit.
  always_comb begin
    w_sum = i_acc + (i_q[0] ? {1'b0, i_op} : '0);
    w_sh  = {i_acc[XLEN-1:0], i_q[XLEN-1]};
    w_ge  = (w_sh >= {1'b0, i_op});
    if (i_div) begin
      o_acc = w_ge ? (w_sh - {1'b0, i_op}) : w_sh;
      o_q   = {i_q[XLEN-2:0], w_ge};
    end else begin
      o_acc = {1'b0, w_sum[XLEN:1]};
      o_q   = {w_sum[0], i_q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// Multi-cycle RV64M sequencer beside the EXE ALU; owns the iterative mul/div datapath.
// Latency: ITER+2 cycles (66 / 34 for W), 2 for divide special cases and fast MUL*.
// Backpressure: MD_BUSY stalls EXE; MD_RESULT held in DONE while MEM_STALL. Macro: MULDIV_FAST_MUL_EN.
module exe_muldiv_ctrl
  import exe_md_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            RESET_N,
  input  logic            MD_REQ,
  input  logic [2:0]      MD_FUNC3,
  input  logic            MD_WORD,
  input  logic [XLEN-1:0] MD_A,
  input  logic [XLEN-1:0] MD_B,
  input  logic            MD_FLUSH,
  input  logic            MEM_STALL,
  output logic            MD_BUSY,
  output logic            MD_DONE,
  output logic [XLEN-1:0] MD_RESULT
);

  md_state_e       r_state, w_next;
  logic [XLEN:0]   r_acc;
  logic [XLEN-1:0] r_q, r_op, r_result;
  logic [CNT_W-1:0] r_cnt, r_iter;
  logic [2:0]      r_func;
  logic            r_word, r_neg, r_spec;

  logic            w_accept, w_is_mul, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
  logic            w_div0, w_ovf, w_spec, w_fast, w_last;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_min, w_spec_val, w_a_sx32;
  logic [XLEN:0]   w_step_acc;
  logic [XLEN-1:0] w_step_q;
  logic [2*XLEN-1:0] w_prod_raw, w_prod;
  logic [XLEN-1:0] w_mul_val, w_div_raw, w_div_val, w_val, w_fix_val;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = (2*XLEN)'(w_a_abs) * (2*XLEN)'(w_b_abs);
  assign w_fast      = w_is_mul;
`else
  assign w_fast      = 1'b0;
`endif

  // Request decode: operand extension, magnitudes, result sign and special divides.
  always_comb begin
    w_accept = (r_state == IDLE) && MD_REQ && !MD_FLUSH;
    w_is_mul = ~MD_FUNC3[2];
    w_a_sgn  = (MD_FUNC3 == F3_MULH) || (MD_FUNC3 == F3_MULHSU) ||
               (MD_FUNC3 == F3_DIV)  || (MD_FUNC3 == F3_REM);
    w_b_sgn  = (MD_FUNC3 == F3_MULH) || (MD_FUNC3 == F3_DIV) || (MD_FUNC3 == F3_REM);
    w_a_sx32 = {{(XLEN-MD_WLEN){MD_A[MD_WLEN-1]}}, MD_A[MD_WLEN-1:0]};
    w_a_ext  = MD_A;
    w_b_ext  = MD_B;
    if (MD_WORD) begin
      w_a_ext = w_a_sgn ? w_a_sx32 : {{(XLEN-MD_WLEN){1'b0}}, MD_A[MD_WLEN-1:0]};
      w_b_ext = w_b_sgn ? {{(XLEN-MD_WLEN){MD_B[MD_WLEN-1]}}, MD_B[MD_WLEN-1:0]}
                        : {{(XLEN-MD_WLEN){1'b0}}, MD_B[MD_WLEN-1:0]};
    end
    w_a_neg  = w_a_sgn & w_a_ext[XLEN-1];
    w_b_neg  = w_b_sgn & w_b_ext[XLEN-1];
    w_a_abs  = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_abs  = w_b_neg ? -w_b_ext : w_b_ext;
    // Remainder takes the dividend's sign; products and quotients take the XOR.
    w_neg    = (!w_is_mul && MD_FUNC3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_min    = MD_WORD ? {{(XLEN-MD_WLEN+1){1'b1}}, {(MD_WLEN-1){1'b0}}}
                       : {1'b1, {(XLEN-1){1'b0}}};
    w_div0   = !w_is_mul && (w_b_ext == '0);
    w_ovf    = !w_is_mul && !MD_FUNC3[0] && (w_a_ext == w_min) && (w_b_ext == '1);
    w_spec   = w_div0 || w_ovf;
    // Special results are formed now and parked in acc so FIX just forwards them.
    if (w_div0)
      w_spec_val = MD_FUNC3[1] ? (MD_WORD ? w_a_sx32 : MD_A) : '1;
    else
      w_spec_val = MD_FUNC3[1] ? '0 : w_a_ext;
  end

  md_step #(.XLEN(XLEN)) u_step (
    .i_div (r_func[2]),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_op  (r_op),
    .o_acc (w_step_acc),
    .o_q   (w_step_q)
  );

  assign w_last = (r_cnt == (r_iter - CNT_W'(1)));

  // Final result: sign fix, hi/lo or quotient/remainder select, W sign-extension.
  always_comb begin
    w_prod_raw = r_word ? (2*XLEN)'({r_acc[MD_WLEN-1:0], r_q[XLEN-1:XLEN-MD_WLEN]})
                        : {r_acc[XLEN-1:0], r_q};
    w_prod     = r_neg ? -w_prod_raw : w_prod_raw;
    w_mul_val  = (r_func == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    w_div_raw  = r_func[1] ? r_acc[XLEN-1:0] : r_q;
    w_div_val  = r_neg ? -w_div_raw : w_div_raw;
    w_val      = r_spec ? r_acc[XLEN-1:0] : (r_func[2] ? w_div_val : w_mul_val);
    w_fix_val  = r_word ? {{(XLEN-MD_WLEN){w_val[MD_WLEN-1]}}, w_val[MD_WLEN-1:0]} : w_val;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state; flush wins over everything, including a new request.
  always_comb begin
    w_next = r_state;
    if (MD_FLUSH) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (MD_REQ) w_next = (w_spec || w_fast) ? FIX : RUN;
        RUN:  if (w_last) w_next = FIX;
        FIX:  w_next = DONE;
        DONE: if (!MEM_STALL) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Outputs: busy until DONE can drain, done while holding the result.
  always_comb begin
    MD_DONE = (r_state == DONE);
    if (r_state == IDLE) MD_BUSY = MD_REQ;
    else                 MD_BUSY = !((r_state == DONE) && !MEM_STALL);
  end

  assign MD_RESULT = r_result;

  // Datapath: latch operands on accept, iterate in RUN, capture result in FIX.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_iter   <= '0;
      r_func   <= '0;
      r_word   <= 1'b0;
      r_neg    <= 1'b0;
      r_spec   <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_func <= MD_FUNC3;
        r_word <= MD_WORD;
        r_neg  <= w_neg;
        r_spec <= w_spec;
        r_cnt  <= '0;
        r_iter <= MD_WORD ? CNT_W'(MD_WLEN) : CNT_W'(XLEN);
        if (w_spec) begin
          r_acc <= {1'b0, w_spec_val};
          r_q   <= '0;
          r_op  <= '0;
        end else if (w_is_mul) begin
          r_op <= w_a_abs;
`ifdef MULDIV_FAST_MUL_EN
          if (MD_WORD) begin
            r_acc <= (XLEN+1)'(w_fast_prod[2*MD_WLEN-1:MD_WLEN]);
            r_q   <= {w_fast_prod[MD_WLEN-1:0], {(XLEN-MD_WLEN){1'b0}}};
          end else begin
            r_acc <= {1'b0, w_fast_prod[2*XLEN-1:XLEN]};
            r_q   <= w_fast_prod[XLEN-1:0];
          end
`else
          r_acc <= '0;
          r_q   <= w_b_abs;
`endif
        end else begin
          // W divides pre-shift the dividend so 32 steps leave the quotient in q[31:0].
          r_acc <= '0;
          r_q   <= MD_WORD ? (w_a_abs << MD_WLEN) : w_a_abs;
          r_op  <= w_b_abs;
        end
      end else if (r_state == RUN) begin
        r_acc <= w_step_acc;
        r_q   <= w_step_q;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == FIX) && !MD_FLUSH) r_result <= w_fix_val;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Self-checking bench for exe_muldiv_ctrl: scoreboard of expected result and latency.
// Expected values come from a behavioural RV64M reference model.
// Covers special cases, MEM_STALL hold, flush and mid-operation reset.
module tb_exe_muldiv_ctrl;
  import exe_md_pkg::*;

  logic        clk = 1'b0;
  logic        RESET_N, MD_REQ, MD_WORD, MD_FLUSH, MEM_STALL;
  logic [2:0]  MD_FUNC3;
  logic [63:0] MD_A, MD_B;
  logic        MD_BUSY, MD_DONE;
  logic [63:0] MD_RESULT;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] last_res = '0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    string       tag;
  } exp_t;
  exp_t scb[$];

  always #5 clk = ~clk;

  exe_muldiv_ctrl dut (
    .clk       (clk),
    .RESET_N   (RESET_N),
    .MD_REQ    (MD_REQ),
    .MD_FUNC3  (MD_FUNC3),
    .MD_WORD   (MD_WORD),
    .MD_A      (MD_A),
    .MD_B      (MD_B),
    .MD_FLUSH  (MD_FLUSH),
    .MEM_STALL (MEM_STALL),
    .MD_BUSY   (MD_BUSY),
    .MD_DONE   (MD_DONE),
    .MD_RESULT (MD_RESULT)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] f3, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sp;
    logic [127:0]        up;
    logic signed [63:0]  sa, sbv;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         a32, b32, r32;
    logic [63:0]         r;
    sa = a; sbv = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    r = '0; r32 = '0;
    if (!w) begin
      case (f3)
        F3_MUL:    r = a * b;
        F3_MULH:   begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = sp[127:64]; end
        F3_MULHSU: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = sp[127:64]; end
        F3_MULHU:  begin up = {64'b0, a} * {64'b0, b}; r = up[127:64]; end
        F3_DIV:    if (b == 0) r = '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a; else r = sa / sbv;
        F3_DIVU:   if (b == 0) r = '1; else r = a / b;
        F3_REM:    if (b == 0) r = a; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0; else r = sa % sbv;
        default:   if (b == 0) r = a; else r = a % b;
      endcase
    end else begin
      case (f3)
        F3_MUL:  r32 = a32 * b32;
        F3_DIV:  if (b32 == 0) r32 = '1; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32; else r32 = sa32 / sb32;
        F3_DIVU: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
        F3_REM:  if (b32 == 0) r32 = a32; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0; else r32 = sa32 % sb32;
        F3_REMU: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 2;
`else
      return (w ? 32 : 64) + 2;
`endif
    end
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 2;
    return (w ? 32 : 64) + 2;
  endfunction

  task automatic drive_req(input logic [2:0] f3, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
    logic [31:0] instr;
    instr    = {FUNCT7_M, 10'b0, f3, 5'b0, (w ? OP32 : OP)};
    MD_REQ   = (instr[31:25] == FUNCT7_M) && ((instr[6:0] == OP) || (instr[6:0] == OP32));
    MD_WORD  = (instr[6:0] == OP32);
    MD_FUNC3 = instr[14:12];
    MD_A     = a;
    MD_B     = b;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input int stall);
    exp_t e;
    int   lat;
    bit   seen;
    e.res = ref_md(f3, w, a, b);
    e.lat = exp_lat(f3, w, a, b);
    e.tag = tag;
    scb.push_back(e);
    drive_req(f3, w, a, b);
    #1 chk({tag, "_busy_req"}, MD_BUSY, 1);
    lat = 0; seen = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      MD_REQ = 1'b0;
      if (MD_DONE) seen = 1;
    end
    e = scb.pop_front();
    if (!seen) begin
      chk({e.tag, "_timeout"}, 0, 1);
      return;
    end
    chk({e.tag, "_lat"}, lat, e.lat);
    for (int k = 1; k <= stall + 1; k++) begin
      if (k == 1 && stall > 0) MEM_STALL = 1'b1;
      if (k == stall + 1) MEM_STALL = 1'b0;
      #1;
      chk({e.tag, "_done"}, MD_DONE, 1);
      chk({e.tag, "_res"}, MD_RESULT, e.res);
      chk({e.tag, "_busy_done"}, MD_BUSY, (k <= stall) ? 1 : 0);
      @(negedge clk);
    end
    #1 chk({e.tag, "_idle"}, MD_DONE, 0);
    last_res = e.res;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    RESET_N = 1'b0; MD_REQ = 1'b0; MD_WORD = 1'b0; MD_FUNC3 = '0;
    MD_A = '0; MD_B = '0; MD_FLUSH = 1'b0; MEM_STALL = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", MD_BUSY, 0);
    chk("rst_done", MD_DONE, 0);
    chk("rst_res", MD_RESULT, 0);
    RESET_N = 1'b1;
    @(negedge clk);

    run_op("divu",    F3_DIVU,   0, 64'd100, 64'd7, 0);
    run_op("remu",    F3_REMU,   0, 64'd100, 64'd7, 0);
    run_op("div",     F3_DIV,    0, -64'sd20, 64'd3, 0);
    run_op("rem",     F3_REM,    0, -64'sd20, 64'd3, 0);
    run_op("divw_ov", F3_DIV,    1, 64'h0000_0000_8000_0000, '1, 0);
    run_op("divu_z",  F3_DIVU,   0, 64'd5, 64'd0, 0);
    run_op("remu_z",  F3_REMU,   0, 64'd5, 64'd0, 0);
    run_op("mulh",    F3_MULH,   0, '1, '1, 0);
    run_op("mulhu",   F3_MULHU,  0, '1, '1, 0);
    run_op("div_ov",  F3_DIV,    0, 64'h8000_0000_0000_0000, '1, 0);
    run_op("remw_z",  F3_REMU,   1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 0);
    run_op("mul",     F3_MUL,    0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    run_op("mulhsu",  F3_MULHSU, 0, {1'b1, 31'($urandom), $urandom}, {$urandom, $urandom}, 0);
    run_op("mulw",    F3_MUL,    1, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    run_op("divuw",   F3_DIVU,   1, {$urandom, $urandom}, {$urandom, 16'h0, 16'($urandom_range(1, 65535))}, 0);
    run_op("remw",    F3_REM,    1, {$urandom, 1'b1, 31'($urandom)}, {$urandom, 20'h0, 12'($urandom_range(3, 4000))}, 0);
    run_op("div_rnd", F3_DIV,    0, {$urandom, $urandom}, {16'hFFFF, 16'($urandom), $urandom}, 0);
    run_op("stall",   F3_DIVU,   0, 64'd1000, 64'd9, 5);

    // Flush in RUN cycle 10 with the request still asserted.
    drive_req(F3_DIVU, 0, 64'd1000, 64'd3);
    repeat (10) @(negedge clk);
    #1 chk("flush_busy_run", MD_BUSY, 1);
    MD_FLUSH = 1'b1;
    @(negedge clk);
    MD_FLUSH = 1'b0; MD_REQ = 1'b0;
    #1;
    chk("flush_busy", MD_BUSY, 0);
    chk("flush_done", MD_DONE, 0);
    chk("flush_res_kept", MD_RESULT, last_res);
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (MD_DONE) ndone++;
    end
    chk("flush_never_done", ndone, 0);

    // Reset in the middle of RUN.
    drive_req(F3_DIVU, 0, 64'd1000, 64'd3);
    @(negedge clk);
    MD_REQ = 1'b0;
    repeat (10) @(negedge clk);
    RESET_N = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_busy", MD_BUSY, 0);
    chk("midrst_done", MD_DONE, 0);
    chk("midrst_res", MD_RESULT, 0);
    RESET_N = 1'b1;
    @(negedge clk);

    run_op("post_rst", F3_MUL, 0, 64'd123456789, 64'd987654321, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
